// File: rtl/pitchfall_pkg.sv
// Shared constants and event record for the pitch-fall engine.
// Widths here are fixed by the pitch/period calculators downstream.
package pitchfall_pkg;

    localparam int FALL_W  = 13;
    localparam int NOTE_W  = 7;
    localparam int SPD_W   = 4;
    localparam int VOICE_W = 4;

    localparam logic [FALL_W-1:0] FALL_MAX = 13'd7680;
    localparam int TICK_LIMIT = 8191;

    // Voice field is wide enough for the largest engine (16 voices).
    typedef struct packed {
        logic [VOICE_W-1:0] voice;
        logic               on;
        logic [NOTE_W-1:0]  note;
        logic               rpt;
    } ev_t;

endpackage

// File: rtl/pitchfall_if.sv
// Event, config and read-port bundle between the voice allocator
// and the pitch-fall engine.
interface pitchfall_if
    import pitchfall_pkg::*;
#(
    parameter int VOICES = 4
);

    localparam int VW = $clog2(VOICES);

    logic              en;
    logic              cfg_we;
    logic [VW-1:0]     cfg_voice;
    logic [SPD_W-1:0]  cfg_speed;
    logic              ev_valid;
    logic              ev_ready;
    logic [VW-1:0]     ev_voice;
    logic              ev_on;
    logic [NOTE_W-1:0] ev_note;
    logic              ev_repeat;
    logic [VW-1:0]     rd_voice;
    logic [FALL_W-1:0] rd_fall;
    logic [VOICES-1:0] active;

    modport master (
        output en, cfg_we, cfg_voice, cfg_speed,
        output ev_valid, ev_voice, ev_on, ev_note, ev_repeat,
        output rd_voice,
        input  ev_ready, rd_fall, active
    );

    modport slave (
        input  en, cfg_we, cfg_voice, cfg_speed,
        input  ev_valid, ev_voice, ev_on, ev_note, ev_repeat,
        input  rd_voice,
        output ev_ready, rd_fall, active
    );

endinterface

// File: rtl/pitchfall_step.sv
// Shared timer/fall datapath: next {fall, timer} for the visited voice.
// Saturation comes from the FALL_MAX compare, so fall never wraps.
module pitchfall_step
    import pitchfall_pkg::*;
#(
    parameter int TIMER_W = 26
) (
    input  logic               started_i,
    input  logic [FALL_W-1:0]  fall_i,
    input  logic [TIMER_W-1:0] timer_i,
    input  logic [SPD_W-1:0]   speed_i,
    output logic [FALL_W-1:0]  fall_o,
    output logic [TIMER_W-1:0] timer_o
);

    always_comb begin
        fall_o  = fall_i;
        timer_o = timer_i;
        if (started_i && fall_i < FALL_MAX) begin
            if (timer_i > TIMER_W'(TICK_LIMIT)) begin
                fall_o  = fall_i + FALL_W'(1);
                timer_o = TIMER_W'(1);
            end else begin
                timer_o = timer_i + (TIMER_W'(1) << speed_i);
            end
        end
    end

endmodule

// File: rtl/pitchfall_sched.sv
// Time-multiplexed pitch-fall engine: one voice stepped per enabled
// cycle by a round-robin slot, with a one-deep event register.
module pitchfall_sched
    import pitchfall_pkg::*;
#(
    parameter int VOICES  = 4,
    parameter int TIMER_W = 26
) (
    input logic       clk,
    input logic       reset,
    pitchfall_if.slave bus
);

    localparam int VW = $clog2(VOICES);

    logic [VOICES-1:0]  started_q, started_d;
    logic [NOTE_W-1:0]  note_q  [VOICES];
    logic [NOTE_W-1:0]  note_d  [VOICES];
    logic [FALL_W-1:0]  fall_q  [VOICES];
    logic [FALL_W-1:0]  fall_d  [VOICES];
    logic [TIMER_W-1:0] timer_q [VOICES];
    logic [TIMER_W-1:0] timer_d [VOICES];
    logic [SPD_W-1:0]   speed_q [VOICES];
    logic [SPD_W-1:0]   speed_d [VOICES];
    logic [VW-1:0]      slot_q, slot_d;
    ev_t                ev_q, ev_d;
    logic               evv_q, evv_d;
    logic [FALL_W-1:0]  rd_q, rd_d;

    logic [FALL_W-1:0]  st_fall;
    logic [TIMER_W-1:0] st_timer;
    logic [VW-1:0]      ev_v;
    logic               accept;

    assign ev_v   = ev_q.voice[VW-1:0];
    assign accept = bus.ev_valid && !evv_q;

    pitchfall_step #(.TIMER_W(TIMER_W)) u_step (
        .started_i (started_q[slot_q]),
        .fall_i    (fall_q[slot_q]),
        .timer_i   (timer_q[slot_q]),
        .speed_i   (speed_q[slot_q]),
        .fall_o    (st_fall),
        .timer_o   (st_timer)
    );

    always_comb begin
        started_d = started_q;
        note_d    = note_q;
        fall_d    = fall_q;
        timer_d   = timer_q;
        speed_d   = speed_q;
        slot_d    = slot_q;
        evv_d     = accept;
        ev_d      = ev_q;
        rd_d      = fall_q[bus.rd_voice];

        if (accept) begin
            ev_d.voice = VOICE_W'(bus.ev_voice);
            ev_d.on    = bus.ev_on;
            ev_d.note  = bus.ev_note;
            ev_d.rpt   = bus.ev_repeat;
        end

        // An event applied to the visited voice overrides its step.
        if (bus.en) begin
            if (!(evv_q && ev_v == slot_q)) begin
                fall_d[slot_q]  = st_fall;
                timer_d[slot_q] = st_timer;
            end
            slot_d = (slot_q == VW'(VOICES - 1)) ? '0 : slot_q + VW'(1);
        end

        if (evv_q) begin
            if (ev_q.on) begin
                if (!(started_q[ev_v] && note_q[ev_v] == ev_q.note
                      && !ev_q.rpt)) begin
                    started_d[ev_v] = 1'b1;
                    fall_d[ev_v]    = '0;
                    timer_d[ev_v]   = TIMER_W'(1);
                    note_d[ev_v]    = ev_q.note;
                end
            end else begin
                started_d[ev_v] = 1'b0;
                note_d[ev_v]    = '0;
            end
        end

        if (bus.cfg_we) begin
            speed_d[bus.cfg_voice] = bus.cfg_speed;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_q <= '0;
            for (int i = 0; i < VOICES; i++) begin
                note_q[i]  <= '0;
                fall_q[i]  <= '0;
                timer_q[i] <= TIMER_W'(1);
                speed_q[i] <= '0;
            end
            slot_q <= '0;
            ev_q   <= '0;
            evv_q  <= 1'b0;
            rd_q   <= '0;
        end else begin
            started_q <= started_d;
            note_q    <= note_d;
            fall_q    <= fall_d;
            timer_q   <= timer_d;
            speed_q   <= speed_d;
            slot_q    <= slot_d;
            ev_q      <= ev_d;
            evv_q     <= evv_d;
            rd_q      <= rd_d;
        end
    end

    assign bus.ev_ready = !evv_q;
    assign bus.rd_fall  = rd_q;
    assign bus.active   = started_q;

endmodule

// File: tb/tb_pitchfall_sched.sv
// Directed plus random checks of pitchfall_sched against a
// voice-level reference model.
module tb_pitchfall_sched;

    localparam int V = 4;
    localparam int FMAX = 7680;
    localparam int TLIM = 8191;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pitchfall_if #(.VOICES(V)) bus ();

    pitchfall_sched #(.VOICES(V)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int m_st [V];
    int m_note [V];
    int m_fall [V];
    int m_tmr [V];
    int m_spd [V];
    int m_slot, m_pend, m_pv, m_pon, m_pnote, m_prep, m_rd;
    int total = 0;
    int bad = 0;
    int rd_fix = -1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < V; i++) begin
            m_st[i] = 0; m_note[i] = 0; m_fall[i] = 0;
            m_tmr[i] = 1; m_spd[i] = 0;
        end
        m_slot = 0; m_pend = 0; m_rd = 0;
        m_pv = 0; m_pon = 0; m_pnote = 0; m_prep = 0;
    endtask

    function automatic int act_vec();
        int a = 0;
        for (int i = 0; i < V; i++) if (m_st[i] != 0) a |= (1 << i);
        return a;
    endfunction

    // One clock: capture inputs, advance the model, compare outputs.
    task automatic tick();
        int c_en, c_we, c_cv, c_cs, c_val, c_vv, c_on, c_note, c_rep, c_rd;
        int nrd, acc, s;
        if (rd_fix < 0) bus.rd_voice = 2'($urandom_range(0, V - 1));
        else bus.rd_voice = 2'(rd_fix);
        c_en = bus.en; c_we = bus.cfg_we; c_cv = bus.cfg_voice;
        c_cs = bus.cfg_speed; c_val = bus.ev_valid; c_vv = bus.ev_voice;
        c_on = bus.ev_on; c_note = bus.ev_note; c_rep = bus.ev_repeat;
        c_rd = bus.rd_voice;
        @(posedge clk);
        nrd = m_fall[c_rd];
        acc = (c_val != 0 && m_pend == 0) ? 1 : 0;
        if (c_en != 0) begin
            s = m_slot;
            if (!(m_pend != 0 && m_pv == s) && m_st[s] != 0
                && m_fall[s] < FMAX) begin
                if (m_tmr[s] > TLIM) begin
                    m_fall[s] += 1;
                    m_tmr[s] = 1;
                end else begin
                    m_tmr[s] += 2 ** m_spd[s];
                end
            end
            m_slot = (m_slot + 1) % V;
        end
        if (m_pend != 0) begin
            if (m_pon != 0) begin
                if (!(m_st[m_pv] != 0 && m_note[m_pv] == m_pnote
                      && m_prep == 0)) begin
                    m_st[m_pv] = 1; m_fall[m_pv] = 0;
                    m_tmr[m_pv] = 1; m_note[m_pv] = m_pnote;
                end
            end else begin
                m_st[m_pv] = 0; m_note[m_pv] = 0;
            end
        end
        if (c_we != 0) m_spd[c_cv] = c_cs;
        m_rd = nrd;
        m_pend = acc;
        if (acc != 0) begin
            m_pv = c_vv; m_pon = c_on; m_pnote = c_note; m_prep = c_rep;
        end
        #1;
        chk("ev_ready", 32'(bus.ev_ready), 32'(m_pend == 0));
        chk("active", 32'(bus.active), 32'(act_vec()));
        chk("rd_fall", 32'(bus.rd_fall), 32'(m_rd));
    endtask

    task automatic send(int v, int on, int note, int rep);
        bus.ev_valid = 1'b1; bus.ev_voice = 2'(v); bus.ev_on = 1'(on);
        bus.ev_note = 7'(note); bus.ev_repeat = 1'(rep);
        tick();
        bus.ev_valid = 1'b0;
        tick();
    endtask

    task automatic set_speed(int v, int sp);
        bus.cfg_we = 1'b1; bus.cfg_voice = 2'(v); bus.cfg_speed = 4'(sp);
        tick();
        bus.cfg_we = 1'b0;
    endtask

    initial begin
        int f0, guard;
        reset = 1'b1;
        bus.en = 1'b0; bus.cfg_we = 1'b0; bus.cfg_voice = '0;
        bus.cfg_speed = '0; bus.ev_valid = 1'b0; bus.ev_voice = '0;
        bus.ev_on = 1'b0; bus.ev_note = '0; bus.ev_repeat = 1'b0;
        bus.rd_voice = '0;
        model_reset();
        #12;
        chk("rst_ready", 32'(bus.ev_ready), 32'd1);
        chk("rst_active", 32'(bus.active), 32'd0);
        chk("rst_rd", 32'(bus.rd_fall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle with the scheduler running.
        bus.en = 1'b1;
        repeat (8) tick();

        // Voice 0 at speed 13: one fall step per 8 enabled cycles.
        set_speed(0, 13);
        send(0, 1, 60, 0);
        repeat (40) tick();

        // Legato hold versus retrigger, scheduler frozen.
        bus.en = 1'b0;
        rd_fix = 0;
        tick(); tick();
        f0 = 32'(bus.rd_fall);
        chk("fall_nonzero", 32'(f0 > 0), 32'd1);
        send(0, 1, 60, 0);
        tick();
        chk("legato_hold", 32'(bus.rd_fall), 32'(f0));
        send(0, 1, 60, 1);
        tick();
        chk("retrigger", 32'(bus.rd_fall), 32'd0);
        rd_fix = -1;

        // Back-to-back valid: ready goes 1, 0, 1.
        bus.en = 1'b1;
        bus.ev_valid = 1'b1; bus.ev_voice = 2'd1; bus.ev_on = 1'b1;
        bus.ev_note = 7'd50; bus.ev_repeat = 1'b0;
        chk("bb_ready0", 32'(bus.ev_ready), 32'd1);
        tick();
        chk("bb_ready1", 32'(bus.ev_ready), 32'd0);
        bus.ev_note = 7'd51;
        tick();
        chk("bb_ready2", 32'(bus.ev_ready), 32'd1);
        tick();
        chk("bb_ready3", 32'(bus.ev_ready), 32'd0);
        bus.ev_valid = 1'b0;
        tick();

        // Event applied to v2 while slot 2 is visited.
        guard = 0;
        while (m_slot != 1 && guard < 8) begin
            tick();
            guard++;
        end
        chk("align_slot", 32'(guard < 8), 32'd1);
        send(2, 1, 70, 0);
        repeat (40) tick();

        // Speed 15 on v3 runs to saturation.
        set_speed(3, 15);
        send(3, 1, 40, 0);
        guard = 0;
        while (m_fall[3] < FMAX && guard < 70000) begin
            tick();
            guard++;
        end
        chk("sat_reached", 32'(guard < 70000), 32'd1);
        repeat (16) tick();
        rd_fix = 3;
        tick(); tick();
        chk("sat_hold", 32'(bus.rd_fall), 32'd7680);
        send(3, 0, 0, 0);
        tick();
        chk("off_active", 32'(bus.active[3]), 32'd0);
        chk("off_fall", 32'(bus.rd_fall), 32'd7680);
        rd_fix = -1;

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            bus.en = 1'($urandom_range(0, 3) != 0);
            bus.cfg_we = 1'($urandom_range(0, 15) == 0);
            bus.cfg_voice = 2'($urandom_range(0, V - 1));
            bus.cfg_speed = 4'($urandom_range(10, 15));
            bus.ev_valid = 1'($urandom_range(0, 5) == 0);
            bus.ev_voice = 2'($urandom_range(0, V - 1));
            bus.ev_on = 1'($urandom_range(0, 3) != 0);
            bus.ev_note = 7'($urandom_range(60, 62));
            bus.ev_repeat = 1'($urandom_range(0, 1));
            tick();
        end
        bus.cfg_we = 1'b0;
        bus.ev_valid = 1'b0;

        // Asynchronous reset mid-run with an event pending.
        bus.en = 1'b1;
        bus.ev_valid = 1'b1; bus.ev_voice = 2'd1; bus.ev_on = 1'b1;
        bus.ev_note = 7'd33;
        tick();
        bus.ev_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_rd", 32'(bus.rd_fall), 32'd0);
        chk("arst_active", 32'(bus.active), 32'd0);
        chk("arst_ready", 32'(bus.ev_ready), 32'd1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        send(1, 1, 20, 0);
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
